// File: rtl/aer_spike_collector.sv
// AER output spike collector: counts handshaken events per output neuron during a
// START/STOP window, then scans the counters for the winning neuron.
module aer_spike_collector #(
    parameter int M       = 10,
    parameter int NUM_OUT = 10,
    parameter int CNT_W   = 8,
    parameter int IW      = $clog2(NUM_OUT)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [M-1:0]     aerout_addr_i,
    input  logic             aerout_req_i,
    output logic             aerout_ack_o,
    input  logic             start_i,
    input  logic             stop_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [IW-1:0]    winner_o,
    output logic [CNT_W-1:0] win_cnt_o,
    output logic             tie_o,
    output logic             oor_err_o,
    input  logic [IW-1:0]    rd_idx_i,
    output logic [CNT_W-1:0] rd_cnt_o
);

    typedef enum logic [2:0] {S_IDLE, S_COLLECT, S_DRAIN, S_SCAN, S_FIN} state_e;

    localparam logic [IW-1:0] LAST_IDX = IW'(NUM_OUT - 1);

    state_e           state_q, state_d;
    logic             req_meta_q, req_s_q;
    logic             ack_q, ack_d;
    logic [CNT_W-1:0] cnt_q [NUM_OUT];
    logic [IW-1:0]    idx_q;
    logic [IW-1:0]    best_idx_q;
    logic [CNT_W-1:0] best_cnt_q;
    logic             best_tie_q;
    logic [IW-1:0]    winner_q;
    logic [CNT_W-1:0] win_cnt_q;
    logic             tie_q;
    logic             done_q;
    logic             oor_q;
    logic [CNT_W-1:0] rd_cnt_q;

    logic             in_idle, in_collect, in_drain, in_scan, in_fin;
    logic             ack_rise, clear, count_en, addr_ok, rd_ok;
    logic [IW-1:0]    addr_idx;
    logic [CNT_W-1:0] scan_cnt;

    // The address is only looked at on the edge ACK rises, when the core holds it stable.
    assign ack_rise = req_s_q & ~ack_q;
    assign addr_ok  = ({1'b0, aerout_addr_i} < (M+1)'(NUM_OUT));
    assign addr_idx = aerout_addr_i[IW-1:0];
    assign clear    = start_i & (in_idle | in_collect);
    assign count_en = in_collect & ack_rise & ~start_i;
    assign rd_ok    = ({1'b0, rd_idx_i} < (IW+1)'(NUM_OUT));
    assign scan_cnt = cnt_q[idx_q];

    always_comb begin
        ack_d = ack_q;
        if (req_s_q && !ack_q)      ack_d = 1'b1;
        else if (!req_s_q && ack_q) ack_d = 1'b0;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            req_meta_q <= 1'b0;
            req_s_q    <= 1'b0;
            ack_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            req_meta_q <= aerout_req_i;
            req_s_q    <= req_meta_q;
            ack_q      <= ack_d;
        end
    end

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (start_i) state_d = S_COLLECT;
            S_COLLECT: if (!start_i && stop_i) state_d = S_DRAIN;
            S_DRAIN:   if (!ack_q && !req_s_q) state_d = S_SCAN;
            S_SCAN:    if (idx_q == LAST_IDX) state_d = S_FIN;
            S_FIN:     state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    always_comb begin
        in_idle    = (state_q == S_IDLE);
        in_collect = (state_q == S_COLLECT);
        in_drain   = (state_q == S_DRAIN);
        in_scan    = (state_q == S_SCAN);
        in_fin     = (state_q == S_FIN);
    end

    // NOTE: the counter array is reset explicitly because a reset must read back all zeros.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_OUT; i++) cnt_q[i] <= '0;
            oor_q <= 1'b0;
        end else if (clear) begin
            for (int i = 0; i < NUM_OUT; i++) cnt_q[i] <= '0;
            oor_q <= 1'b0;
        end else if (count_en) begin
            if (!addr_ok) oor_q <= 1'b1;
            for (int i = 0; i < NUM_OUT; i++) begin
                if (addr_ok && addr_idx == IW'(i) && cnt_q[i] != '1)
                    cnt_q[i] <= cnt_q[i] + 1'b1;
            end
        end
    end

    // Strictly-greater replacement keeps the lowest index on ties.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q      <= '0;
            best_idx_q <= '0;
            best_cnt_q <= '0;
            best_tie_q <= 1'b0;
            winner_q   <= '0;
            win_cnt_q  <= '0;
            tie_q      <= 1'b0;
            done_q     <= 1'b0;
            rd_cnt_q   <= '0;
        end else begin
            done_q   <= 1'b0;
            rd_cnt_q <= rd_ok ? cnt_q[rd_idx_i] : '0;
            if (in_drain) begin
                idx_q      <= '0;
                best_idx_q <= '0;
                best_cnt_q <= '0;
                best_tie_q <= 1'b0;
            end else if (in_scan) begin
                if (idx_q != LAST_IDX) idx_q <= idx_q + 1'b1;
                if (scan_cnt > best_cnt_q) begin
                    best_cnt_q <= scan_cnt;
                    best_idx_q <= idx_q;
                    best_tie_q <= 1'b0;
                end else if (scan_cnt == best_cnt_q && best_cnt_q != '0) begin
                    best_tie_q <= 1'b1;
                end
            end else if (in_fin) begin
                winner_q  <= best_idx_q;
                win_cnt_q <= best_cnt_q;
                tie_q     <= best_tie_q;
                done_q    <= 1'b1;
            end
        end
    end

    assign aerout_ack_o = ack_q;
    assign busy_o       = ~in_idle;
    assign done_o       = done_q;
    assign winner_o     = winner_q;
    assign win_cnt_o    = win_cnt_q;
    assign tie_o        = tie_q;
    assign oor_err_o    = oor_q;
    assign rd_cnt_o     = rd_cnt_q;

endmodule

// File: tb/tb_aer_spike_collector.sv
// Directed bench for aer_spike_collector: table of event windows with expected winners,
// plus hand-written sequences for idle events, START/STOP collision, drain delay and reset.
module tb_aer_spike_collector;

    localparam int M       = 10;
    localparam int NUM_OUT = 10;
    localparam int CNT_W   = 4;
    localparam int IW      = $clog2(NUM_OUT);

    logic             clk = 1'b0;
    logic             rst_n;
    logic [M-1:0]     addr;
    logic             req, ack, start, stop, busy, done, tie, oor;
    logic [IW-1:0]    winner, rd_idx;
    logic [CNT_W-1:0] win_cnt, rd_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    aer_spike_collector #(.M(M), .NUM_OUT(NUM_OUT), .CNT_W(CNT_W), .IW(IW)) dut (
        .clk(clk), .rst_n(rst_n),
        .aerout_addr_i(addr), .aerout_req_i(req), .aerout_ack_o(ack),
        .start_i(start), .stop_i(stop), .busy_o(busy), .done_o(done),
        .winner_o(winner), .win_cnt_o(win_cnt), .tie_o(tie), .oor_err_o(oor),
        .rd_idx_i(rd_idx), .rd_cnt_o(rd_cnt)
    );

    // Events: na at address a, then nb at address b; expected results and one readback.
    typedef struct {
        int a; int na; int b; int nb;
        int w; int c; int t; int o;
        int rd; int rdv;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // All tasks start and end right at a falling edge.
    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_event(input int a);
        addr = M'(a);
        req  = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (ack) break;
        end
        check("ack_rise", ack, 1);
        req = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!ack) break;
        end
        check("ack_fall", ack, 0);
    endtask

    // Pulse STOP; k = edges after the STOP-sampling edge until DONE is seen.
    task automatic run_stop(input int drop_at, output int k);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        k = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            k++;
            if (k == drop_at) req = 1'b0;
            if (done) break;
        end
        check("done_seen", done, 1);
    endtask

    task automatic read_cnt(input int idx, input int exp, input string name);
        rd_idx = IW'(idx);
        @(negedge clk);
        check(name, rd_cnt, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int seen;

        vecs[0] = '{a:3,  na:3,  b:7, nb:1, w:3, c:3,  t:0, o:0, rd:3, rdv:3};
        vecs[1] = '{a:2,  na:5,  b:6, nb:5, w:2, c:5,  t:1, o:0, rd:6, rdv:5};
        vecs[2] = '{a:1,  na:20, b:0, nb:0, w:1, c:15, t:0, o:0, rd:1, rdv:15};
        vecs[3] = '{a:12, na:1,  b:4, nb:2, w:4, c:2,  t:0, o:1, rd:4, rdv:2};
        vecs[4] = '{a:9,  na:2,  b:0, nb:0, w:9, c:2,  t:0, o:0, rd:9, rdv:2};
        vecs[5] = '{a:0,  na:0,  b:0, nb:0, w:0, c:0,  t:0, o:0, rd:9, rdv:0};
        vecs[6] = '{a:8,  na:3,  b:5, nb:4, w:5, c:4,  t:0, o:0, rd:8, rdv:3};
        vecs[7] = '{a:0,  na:1,  b:9, nb:1, w:0, c:1,  t:1, o:0, rd:9, rdv:1};

        rst_n = 1'b0; addr = '0; req = 1'b0; start = 1'b0; stop = 1'b0; rd_idx = '0;
        repeat (3) @(negedge clk);
        check("rst_ack", ack, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_winner", winner, 0);
        check("rst_win_cnt", win_cnt, 0);
        check("rst_tie", tie, 0);
        check("rst_oor", oor, 0);
        check("rst_rd_cnt", rd_cnt, 0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int v = 0; v < 8; v++) begin
            pulse_start();
            check($sformatf("v%0d_busy", v), busy, 1);
            check($sformatf("v%0d_oor_clear", v), oor, 0);
            for (int j = 0; j < vecs[v].na; j++) send_event(vecs[v].a);
            for (int j = 0; j < vecs[v].nb; j++) send_event(vecs[v].b);
            run_stop(0, k);
            check($sformatf("v%0d_latency", v), k, NUM_OUT + 2);
            check($sformatf("v%0d_winner", v), winner, vecs[v].w);
            check($sformatf("v%0d_win_cnt", v), win_cnt, vecs[v].c);
            check($sformatf("v%0d_tie", v), tie, vecs[v].t);
            check($sformatf("v%0d_oor", v), oor, vecs[v].o);
            check($sformatf("v%0d_idle", v), busy, 0);
            @(negedge clk);
            check($sformatf("v%0d_done_pulse", v), done, 0);
            read_cnt(vecs[v].rd, vecs[v].rdv, $sformatf("v%0d_rd_cnt", v));
        end

        // Idle event is acknowledged but not counted; STOP in idle is ignored.
        send_event(0);
        read_cnt(0, 1, "idle_event_not_counted");
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        check("idle_stop_busy", busy, 0);
        seen = 0;
        repeat (14) begin
            @(negedge clk);
            if (done) seen = 1;
        end
        check("idle_stop_no_done", seen, 0);

        // START and STOP together while collecting: START wins and clears the window.
        pulse_start();
        send_event(3);
        start = 1'b1; stop = 1'b1;
        @(negedge clk);
        start = 1'b0; stop = 1'b0;
        check("collide_busy", busy, 1);
        run_stop(0, k);
        check("collide_latency", k, NUM_OUT + 2);
        check("collide_winner", winner, 0);
        check("collide_win_cnt", win_cnt, 0);
        read_cnt(3, 0, "collide_rd_cnt");

        // STOP while ACK is high and REQ stays up: DRAIN waits, the event still counts.
        pulse_start();
        send_event(2);
        addr = M'(5);
        req  = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (ack) break;
        end
        check("drain_ack_high", ack, 1);
        run_stop(5, k);
        check("drain_latency", k, NUM_OUT + 10);
        check("drain_winner", winner, 2);
        check("drain_win_cnt", win_cnt, 1);
        check("drain_tie", tie, 1);
        read_cnt(5, 1, "drain_rd_cnt");

        // Reset mid-handshake drops ACK at once; a held REQ is a fresh, uncounted event.
        pulse_start();
        addr = M'(4);
        req  = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (ack) break;
        end
        check("mid_rst_ack_before", ack, 1);
        #1 rst_n = 1'b0;
        #1;
        check("mid_rst_ack", ack, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_winner", winner, 0);
        check("mid_rst_win_cnt", win_cnt, 0);
        check("mid_rst_tie", tie, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_oor", oor, 0);
        check("mid_rst_rd_cnt", rd_cnt, 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (ack) break;
        end
        check("post_rst_reack", ack, 1);
        req = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!ack) break;
        end
        check("post_rst_ack_fall", ack, 0);
        read_cnt(4, 0, "post_rst_not_counted");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/aer_spike_collector.md
AER_SPIKE_COLLECTOR -- requirements
Module: aer_spike_collector

Interface
REQ-001 Parameter M, default 10, output AER address width of the SNN core.
REQ-002 Parameter NUM_OUT, default 10, number of counted output neurons, range 2..2^M.
REQ-003 Parameter CNT_W, default 8, per-neuron spike counter width.
REQ-004 Parameter IW, default $clog2(NUM_OUT), width of the neuron index.
REQ-005 CLK  in  1  single system clock; all logic on the rising edge.
REQ-006 RST_N  in  1  asynchronous, active-low reset.
REQ-007 AEROUT_ADDR  in  M  spiking neuron address from the core; stable while AEROUT_REQ is high.
REQ-008 AEROUT_REQ  in  1  core event request, asynchronous to CLK.
REQ-009 AEROUT_ACK  out  1  4-phase acknowledge to the core, registered.
REQ-010 START  in  1  one-cycle pulse; clears counters and opens the collection window.
REQ-011 STOP  in  1  one-cycle pulse; closes the window and starts winner evaluation.
REQ-012 BUSY  out  1  high in every state except IDLE.
REQ-013 DONE  out  1  one-cycle pulse when WINNER, WIN_CNT and TIE are valid.
REQ-014 WINNER  out  IW  index of the neuron with the maximum count.
REQ-015 WIN_CNT  out  CNT_W  maximum count.
REQ-016 TIE  out  1  another index equals a nonzero maximum.
REQ-017 OOR_ERR  out  1  sticky flag: an event with AEROUT_ADDR >= NUM_OUT arrived during COLLECT.
REQ-018 RD_IDX  in  IW  counter read index.
REQ-019 RD_CNT  out  CNT_W  registered count of RD_IDX, valid 1 cycle after RD_IDX.

Function
REQ-020 AEROUT_REQ SHALL pass through a 2-FF synchroniser (req_s) before use; AEROUT_ADDR SHALL be sampled only when ACK rises.
REQ-021 Handshake: if req_s=1 and ACK=0, ACK SHALL go to 1 on the next edge. If req_s=0 and ACK=1, ACK SHALL go to 0 on the next edge. In all other cases ACK SHALL hold.
REQ-022 Events SHALL be acknowledged in every state, so the core never stalls. An event SHALL be counted only if ACK rises while the state is COLLECT.
REQ-023 A counted event SHALL increment count[addr] on the same edge ACK rises. The count SHALL saturate at 2^CNT_W-1 with no wrap.
REQ-024 An event with addr >= NUM_OUT during COLLECT SHALL NOT change any counter and SHALL set OOR_ERR.
REQ-025 FSM states: IDLE, COLLECT, DRAIN, SCAN, FIN.
REQ-026 IDLE->COLLECT on START: all counters and OOR_ERR cleared on the same edge.
REQ-027 COLLECT with START again: counters and OOR_ERR cleared, state stays COLLECT. COLLECT->DRAIN on STOP.
REQ-028 START and STOP in the same cycle: START SHALL win in IDLE and COLLECT. STOP in IDLE SHALL be ignored.
REQ-029 DRAIN->SCAN on the first cycle with ACK=0 and req_s=0. An event already acknowledged before DRAIN SHALL already be counted.
REQ-030 SCAN SHALL visit idx 0..NUM_OUT-1, one index per cycle. A candidate SHALL replace the best only if strictly greater, so the lowest index wins ties.
REQ-031 TIE SHALL be set if a later idx equals the current best and the best is > 0.
REQ-032 SCAN->FIN after idx NUM_OUT-1. In FIN: WINNER, WIN_CNT and TIE SHALL be updated, DONE=1 for one cycle, then the state SHALL return to IDLE.
REQ-033 Latency with no handshake pending: DONE SHALL be high in cycle t+NUM_OUT+2, where STOP is sampled at edge t.
REQ-034 START and STOP SHALL be ignored in DRAIN, SCAN and FIN.
REQ-035 WINNER, WIN_CNT and TIE SHALL hold from FIN until the next FIN or reset. Counters SHALL hold after FIN until the next START.
REQ-036 All counts zero: WINNER=0, WIN_CNT=0, TIE=0.

Reset
REQ-037 RST_N low SHALL immediately set: state IDLE, ACK=0, synchroniser 0, all counters 0, WINNER=0, WIN_CNT=0, TIE=0, DONE=0, BUSY=0, OOR_ERR=0, RD_CNT=0.
REQ-038 Reset mid-handshake SHALL drop ACK without counting. After release, a still-high AEROUT_REQ SHALL be treated as a new event.

Verification
REQ-039 START; events at addrs 3,3,7,3; STOP -> DONE at t+12 (NUM_OUT=10), WINNER=3, WIN_CNT=3, TIE=0.
REQ-040 START; 5 events at addr 2 and 5 at addr 6; STOP -> WINNER=2, WIN_CNT=5, TIE=1.
REQ-041 CNT_W=4; 20 events at addr 1 -> RD_IDX=1 gives RD_CNT=15, and WIN_CNT=15.
REQ-042 Event at addr 12 during COLLECT -> ACK completes, no count change, OOR_ERR=1. Next START -> OOR_ERR=0.
REQ-043 STOP while ACK=1 with REQ held 6 cycles -> DRAIN holds until ACK=0, the event is counted, and DONE is delayed accordingly. Events in IDLE are acked but not counted.
REQ-044 RST_N low while ACK=1 -> ACK=0 immediately and all outputs at reset values.
